// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes and control states.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SLT = 3'b011;
    localparam logic [OP_W-1:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True when the op code selects the iterative multiplier.
    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
module alu_shift_add_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done_c,
    output logic [2*WIDTH-1:0]   product_c
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    addend;

    // Next accumulator value; on the last step this is the finished product.
    // done_c marks the last multiplier bit and must be qualified with busy.
    always_comb begin
        addend    = mplier[0] ? mcand : '0;
        product_c = acc + addend;
        done_c    = (cnt == CNT_W'(1));
    end

    // Operand capture on start, then one partial-product step per cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_nbit_seq.sv
// WIDTH-bit ALU stage with valid/ready on both sides and registered, held results.
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ainvert_in,
    input  logic             binvert_in,
    input  logic [OP_W-1:0]  op_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             zero_out
);

    localparam int unsigned M = WIDTH - 1;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done_c;
    logic             mul_finish;
    logic [2*WIDTH-1:0] mul_product_c;

    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

    // Ready only in IDLE and never while reset is being applied.
    assign ready_out  = (state == S_IDLE) & rst_n_in;
    assign accept     = valid_in & ready_out;
    assign mul_start  = accept & is_mul(op_in);
    assign mul_finish = (state == S_MUL) & mul_busy & mul_done_c;

    alu_shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start     (mul_start),
        .a         (a_in),
        .b         (b_in),
        .busy      (mul_busy),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    // Single-cycle ALU on the live inputs; sampled only on the accept edge.
    always_comb begin
        wa        = ainvert_in ? ~a_in : a_in;
        wb        = binvert_in ? ~b_in : b_in;
        sum       = {1'b0, wa} + {1'b0, wb} + {{WIDTH{1'b0}}, binvert_in};
        add_ovf   = (wa[M] == wb[M]) & (sum[M] != wa[M]);
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_in)
            OP_AND: alu_res = wa & wb;
            OP_OR:  alu_res = wa | wb;
            OP_ADD: begin
                alu_res   = sum[M:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_SLT: begin
                alu_res   = {{M{1'b0}}, sum[M] ^ add_ovf};
                alu_carry = sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            default: ;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: no drain and accept in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = is_mul(op_in) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mul_busy && mul_done_c) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_in) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result and flag registers; held until drained, kept (except valid) in IDLE.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_out    <= 1'b0;
            result_out   <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            zero_out     <= 1'b0;
        end else begin
            if (accept && !is_mul(op_in)) begin
                valid_out    <= 1'b1;
                result_out   <= alu_res;
                carry_out    <= alu_carry;
                overflow_out <= alu_ovf;
                zero_out     <= (alu_res == '0);
            end else if (mul_finish) begin
                valid_out    <= 1'b1;
                result_out   <= mul_product_c[M:0];
                carry_out    <= 1'b0;
                overflow_out <= |mul_product_c[2*WIDTH-1:WIDTH];
                zero_out     <= (mul_product_c[M:0] == '0);
            end else if ((state == S_DONE) && ready_in) begin
                valid_out    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed self-checking bench for alu_nbit_seq at WIDTH=8.
module tb_alu_nbit_seq;

    localparam int unsigned W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ainvert_in;
    logic         binvert_in;
    logic [2:0]   op_in;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] result_out;
    logic         carry_out;
    logic         overflow_out;
    logic         zero_out;

    int checks = 0;
    int errors = 0;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .a_in         (a_in),
        .b_in         (b_in),
        .ainvert_in   (ainvert_in),
        .binvert_in   (binvert_in),
        .op_in        (op_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .result_out   (result_out),
        .carry_out    (carry_out),
        .overflow_out (overflow_out),
        .zero_out     (zero_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ai, input logic bi, input logic [2:0] op);
        a_in       = a;
        b_in       = b;
        ainvert_in = ai;
        binvert_in = bi;
        op_in      = op;
        valid_in   = 1'b1;
        step();
        valid_in   = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] res,
                              input logic c, input logic o, input logic z);
        chk({tag, "_valid"}, valid_out, 1'b1);
        chk({tag, "_result"}, result_out, res);
        chk({tag, "_carry"}, carry_out, c);
        chk({tag, "_ovf"}, overflow_out, o);
        chk({tag, "_zero"}, zero_out, z);
    endtask

    task automatic drain();
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        chk("drain_valid", valid_out, 1'b0);
        chk("drain_ready", ready_out, 1'b1);
    endtask

    // Waits for valid_out after a MUL accept; returns cycles since the accept edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (valid_out !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic seen;

        rst_n_in   = 1'b0;
        valid_in   = 1'b0;
        ready_in   = 1'b0;
        a_in       = '0;
        b_in       = '0;
        ainvert_in = 1'b0;
        binvert_in = 1'b0;
        op_in      = 3'b000;

        // Reset state
        step();
        step();
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_result", result_out, 8'h00);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_ovf", overflow_out, 1'b0);
        chk("rst_zero", zero_out, 1'b0);
        chk("rst_ready_low", ready_out, 1'b0);
        rst_n_in = 1'b1;
        #1;
        chk("rst_ready_high", ready_out, 1'b1);
        step();

        // ADD with carry out and zero result
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 3'b010);
        expect_res("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1);
        chk("add_ready_in_done", ready_out, 1'b0);
        drain();

        // SUB with signed overflow
        issue(8'h80, 8'h01, 1'b0, 1'b1, 3'b010);
        expect_res("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0);
        drain();

        // SLT both directions
        issue(8'hFE, 8'h01, 1'b0, 1'b1, 3'b011);
        expect_res("slt_fe_01", 8'h01, 1'b1, 1'b0, 1'b0);
        drain();
        issue(8'h01, 8'hFE, 1'b0, 1'b1, 3'b011);
        expect_res("slt_01_fe", 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // AND / OR and inverted variants
        issue(8'hF0, 8'h3C, 1'b0, 1'b0, 3'b000);
        expect_res("and", 8'h30, 1'b0, 1'b0, 1'b0);
        drain();
        issue(8'hF0, 8'h3C, 1'b0, 1'b0, 3'b001);
        expect_res("or", 8'hFC, 1'b0, 1'b0, 1'b0);
        drain();
        issue(8'hF0, 8'h3C, 1'b1, 1'b0, 3'b000);
        expect_res("and_ainv", 8'h0C, 1'b0, 1'b0, 1'b0);
        drain();
        issue(8'hF0, 8'h0C, 1'b1, 1'b1, 3'b001);
        expect_res("or_abinv", 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();

        // Reserved op after a non-zero result
        issue(8'hFF, 8'hFF, 1'b0, 1'b0, 3'b101);
        expect_res("reserved", 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // MUL latency and result
        issue(8'h0F, 8'h11, 1'b0, 1'b0, 3'b100);
        chk("mul_ready_busy", ready_out, 1'b0);
        chk("mul_valid_early", valid_out, 1'b0);
        wait_valid(lat);
        chk("mul_latency", lat, 9);
        expect_res("mul_0f_11", 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();

        issue(8'h10, 8'h10, 1'b0, 1'b0, 3'b100);
        wait_valid(lat);
        chk("mul2_latency", lat, 9);
        expect_res("mul_10_10", 8'h00, 1'b0, 1'b1, 1'b1);
        drain();

        // MUL ignores inversion controls
        issue(8'h03, 8'h05, 1'b1, 1'b1, 3'b100);
        wait_valid(lat);
        expect_res("mul_inv_ignored", 8'h0F, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure: result held, new operands refused
        issue(8'h12, 8'h34, 1'b0, 1'b0, 3'b010);
        a_in     = 8'hAA;
        b_in     = 8'h55;
        op_in    = 3'b001;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_res("bp_hold", 8'h46, 1'b0, 1'b0, 1'b0);
            chk("bp_ready", ready_out, 1'b0);
            step();
        end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        valid_in = 1'b0;
        chk("bp_drain_valid", valid_out, 1'b0);
        chk("bp_drain_ready", ready_out, 1'b1);
        chk("bp_result_kept", result_out, 8'h46);
        step();
        chk("bp_no_capture", valid_out, 1'b0);

        // Reset during the 4th MUL cycle
        issue(8'h07, 8'h05, 1'b0, 1'b0, 3'b100);
        step();
        step();
        step();
        rst_n_in = 1'b0;
        #1;
        chk("midrst_ready_low", ready_out, 1'b0);
        step();
        rst_n_in = 1'b1;
        #1;
        chk("midrst_valid", valid_out, 1'b0);
        chk("midrst_result", result_out, 8'h00);
        chk("midrst_ready", ready_out, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid_out !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_late_valid", seen, 1'b0);
        issue(8'h03, 8'h04, 1'b0, 1'b0, 3'b010);
        expect_res("post_rst_add", 8'h07, 1'b0, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
